reg_lock_scoreboard: RTL and testbench
======================================

// Module: reg_lock_scoreboard
// PURPOSE
//  Owns the register lock table of the issue stage and sequences issue against it.
//  Holds one lock bit per architectural register; sets the lock on issue, clears it on writeback.
//  Enforces RAW/WAW hazards and serialises blocking instructions through a drain/hold FSM.
//  Sits between decode (issue handshake) and the execution units (writeback unlock ports).
// PARAMETERS
//  NR     32  number of architectural registers (x0 is never lockable)
//  NWB    2   number of independent writeback unlock ports
//  SCW    32  width of the saturating issue-stall counter
// PORTS
//  clk_i         in   1              clock, all state updates on rising edge
//  rst_i         in   1              synchronous, active-high reset
//  pl_valid_i    in   1              decode presents an instruction (held until fire)
//  pl_ready_o    out  1              scoreboard accepts; fire = pl_valid_i & pl_ready_o
//  blocking_i    in   1              instruction is blocking (needs whole register file)
//  rd_i          in   $clog2(NR)     destination register index
//  reg_req_i     in   NR             one-hot-per-bit set of required source registers
//  wb_valid_i    in   NWB            writeback port k releases wb_rd_i[k]
//  wb_rd_i       in   NWB*$clog2(NR) packed writeback register indices
//  blk_done_i    in   1              in-flight blocking instruction has retired
//  flush_i       in   1              pipeline flush: drop every lock
//  locks_o       out  NR             registered lock table
//  busy_o        out  1              FSM not in RUN
//  err_o         out  1              sticky: writeback to an unlocked register (x0 excluded)
//  stall_cnt_o   out  SCW            cycles with pl_valid_i & ~pl_ready_o, saturating
// BEHAVIOUR
//  Reset: locks_o=0, state=RUN, err_o=0, stall_cnt_o=0, busy_o=0; pl_ready_o is comb, =0 unless valid.
//  Hazard check uses registered locks_o only (no same-cycle writeback bypass): ok_src = ~|(locks_o & reg_req_i);
//   ok_rd = ~locks_o[rd_i] (x0 always ok).
//  FSM states RUN, DRAIN, BLOCKED:
//   RUN:  non-blocking: pl_ready_o = ok_src & ok_rd; fire sets locks[rd_i] if rd_i!=0 (next cycle).
//         blocking: if locks_o==0 then pl_ready_o=1, fire -> BLOCKED, locks_o<= all ones;
//         else pl_ready_o=0, -> DRAIN.
//   DRAIN: pl_ready_o = pl_valid_i & blocking_i & (locks_o==0); fire -> BLOCKED, locks<= all ones.
//          pl_valid_i or blocking_i deasserted -> RUN (protocol violation tolerated, no lock change).
//   BLOCKED: pl_ready_o=0; wb_valid_i ignored (no err); blk_done_i -> locks<=0, state RUN next cycle.
//  blk_done_i outside BLOCKED is ignored.
//  Writeback: each valid port clears locks[wb_rd_i[k]]; index 0 ignored; clearing an unlocked bit sets err_o.
//  Two ports naming same register in one cycle: single clear, no err.
//  Same-cycle set (issue) and clear (writeback) of one bit: set wins (cannot occur for rd!=0 under ok_rd; defined anyway).
//  Priority per cycle: rst_i > flush_i > FSM/issue/writeback. flush_i: locks<=0, state<=RUN, pl_ready_o forced 0
//   that cycle, err_o and stall_cnt_o retained.
//  Latency: lock visible on locks_o 1 cycle after fire; release visible 1 cycle after writeback.
//  Back-to-back independent issues accepted every cycle.
//  stall_cnt_o increments by 1 per stall cycle (incl. DRAIN/BLOCKED), holds at all ones.
//  busy_o = (state!=RUN), registered.
// TESTING
//  1 Reset then issue rd=5, req=0 -> ready=1; next cycle locks_o=0x20; issue req bit5 -> ready=0,
//    stall_cnt_o increments.
//  2 wb_valid[0]=1, wb_rd=5 while dependent waits -> ready stays 0 that cycle, =1 next cycle;
//    locks_o=0 then 0x20 again if rd=5.
//  3 Issue rd=0 -> locks_o unchanged (0); wb to x0 -> no err; wb to unlocked x7 -> err_o=1 sticky.
//  4 locks_o=0x0C, blocking arrives -> DRAIN, busy_o=1; wb x2,x3 on two ports same cycle -> locks=0,
//    fire next cycle -> locks_o=all ones, BLOCKED.
//  5 In BLOCKED, non-blocking valid -> ready=0; blk_done_i=1 -> locks_o=0, RUN, busy_o=0 next cycle.
//  6 flush_i mid-DRAIN with locks 0x30 -> locks_o=0, RUN next cycle, err_o/stall_cnt_o unchanged;
//    rst_i mid-BLOCKED -> all reset values.

Source files
------------

// File: rtl/reg_lock_scoreboard.sv
// Register lock scoreboard for the issue stage: tracks per-register locks, gates issue on
// RAW/WAW hazards and serialises blocking instructions through a RUN/DRAIN/BLOCKED FSM.
module reg_lock_scoreboard #(
    parameter int unsigned NR  = 32,
    parameter int unsigned NWB = 2,
    parameter int unsigned SCW = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    pl_valid_i,
    output logic                    pl_ready_o,
    input  logic                    blocking_i,
    input  logic [$clog2(NR)-1:0]   rd_i,
    input  logic [NR-1:0]           reg_req_i,
    input  logic [NWB-1:0]          wb_valid_i,
    input  logic [NWB*$clog2(NR)-1:0] wb_rd_i,
    input  logic                    blk_done_i,
    input  logic                    flush_i,
    output logic [NR-1:0]           locks_o,
    output logic                    busy_o,
    output logic                    err_o,
    output logic [SCW-1:0]          stall_cnt_o
);

    localparam int unsigned AW = $clog2(NR);

    typedef enum logic [1:0] {StRun, StDrain, StBlocked} state_e;

    state_e          state_q, state_d;
    logic [NR-1:0]   locks_q, locks_d;
    logic            err_q, err_set;
    logic [SCW-1:0]  stall_q;
    logic            locks_clear, ok_src, ok_rd, fire, stall_inc;
    logic [AW-1:0]   wb_idx;

    assign locks_clear = (locks_q == '0);
    assign ok_src      = ~|(locks_q & reg_req_i);
    assign ok_rd       = (rd_i == '0) || !locks_q[rd_i];
    assign fire        = pl_valid_i && pl_ready_o;
    // A flush cycle neither issues nor counts as a stall.
    assign stall_inc   = pl_valid_i && !pl_ready_o && !flush_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StRun;
            locks_q <= '0;
            err_q   <= 1'b0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            locks_q <= locks_d;
            err_q   <= err_q | err_set;
            if (stall_inc && (stall_q != '1)) begin
                stall_q <= stall_q + SCW'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StRun: begin
                if (pl_valid_i && blocking_i) begin
                    state_d = fire ? StBlocked : StDrain;
                end
            end
            StDrain: begin
                if (!(pl_valid_i && blocking_i)) begin
                    state_d = StRun;
                end else if (fire) begin
                    state_d = StBlocked;
                end
            end
            StBlocked: begin
                if (blk_done_i) begin
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
        if (flush_i) begin
            state_d = StRun;
        end
    end

    always_comb begin
        pl_ready_o = 1'b0;
        if (pl_valid_i && !flush_i) begin
            case (state_q)
                StRun:   pl_ready_o = blocking_i ? locks_clear : (ok_src && ok_rd);
                StDrain: pl_ready_o = blocking_i && locks_clear;
                default: pl_ready_o = 1'b0;
            endcase
        end
    end

    // Writeback clears are applied first so an issue set to the same bit wins.
    always_comb begin
        locks_d = locks_q;
        err_set = 1'b0;
        wb_idx  = '0;
        if (state_q != StBlocked) begin
            for (int unsigned k = 0; k < NWB; k++) begin
                wb_idx = wb_rd_i[k*AW +: AW];
                if (wb_valid_i[k] && (wb_idx != '0)) begin
                    if (!locks_q[wb_idx]) begin
                        err_set = 1'b1;
                    end
                    locks_d[wb_idx] = 1'b0;
                end
            end
        end
        if (fire && !blocking_i && (rd_i != '0)) begin
            locks_d[rd_i] = 1'b1;
        end
        if (fire && blocking_i) begin
            locks_d = '1;
        end
        if ((state_q == StBlocked) && blk_done_i) begin
            locks_d = '0;
        end
        if (flush_i) begin
            locks_d = '0;
            err_set = 1'b0;
        end
    end

    assign locks_o     = locks_q;
    assign busy_o      = (state_q != StRun);
    assign err_o       = err_q;
    assign stall_cnt_o = stall_q;

endmodule

// File: tb/tb_reg_lock_scoreboard.sv
// Directed table-driven bench for reg_lock_scoreboard: each record drives one cycle and
// checks the combinational ready plus the registered state after the edge.
module tb_reg_lock_scoreboard;

    logic        clk, rst, pl_valid, pl_ready, blocking, blk_done, flush, busy, err;
    logic [4:0]  rd;
    logic [31:0] reg_req, locks, stall_cnt;
    logic [1:0]  wb_valid;
    logic [9:0]  wb_rd;

    reg_lock_scoreboard #(.NR(32), .NWB(2), .SCW(32)) dut (
        .clk_i(clk), .rst_i(rst), .pl_valid_i(pl_valid), .pl_ready_o(pl_ready),
        .blocking_i(blocking), .rd_i(rd), .reg_req_i(reg_req), .wb_valid_i(wb_valid),
        .wb_rd_i(wb_rd), .blk_done_i(blk_done), .flush_i(flush), .locks_o(locks),
        .busy_o(busy), .err_o(err), .stall_cnt_o(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, flush, valid, blk, done;
        logic [4:0]  rd;
        logic [31:0] req;
        logic [1:0]  wbv;
        logic [4:0]  wr0, wr1;
        logic        e_ready;
        logic [31:0] e_locks;
        logic        e_busy, e_err;
        logic [31:0] e_stall;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    task automatic add(input logic r, f, v, b, d, input logic [4:0] rdv, input logic [31:0] rq,
                       input logic [1:0] wv, input logic [4:0] w0, w1, input logic er,
                       input logic [31:0] el, input logic eb, ee, input logic [31:0] es);
        vec_t t;
        t.rst = r; t.flush = f; t.valid = v; t.blk = b; t.done = d; t.rd = rdv; t.req = rq;
        t.wbv = wv; t.wr0 = w0; t.wr1 = w1; t.e_ready = er; t.e_locks = el; t.e_busy = eb;
        t.e_err = ee; t.e_stall = es;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        rst = t.rst; flush = t.flush; pl_valid = t.valid; blocking = t.blk; blk_done = t.done;
        rd = t.rd; reg_req = t.req; wb_valid = t.wbv; wb_rd = {t.wr1, t.wr0};
    endtask

    initial begin
        vec_t idle;
        rst = 1'b1; flush = 1'b0; pl_valid = 1'b0; blocking = 1'b0; blk_done = 1'b0;
        rd = '0; reg_req = '0; wb_valid = '0; wb_rd = '0;

        //   rst f  v  b  d  rd  req          wbv    w0 w1  rdy locks        bsy err stall
        add(1, 0, 0, 0, 0, 0,  32'h0,        2'b00, 0, 0,  0,  32'h0,       0,  0,  0); // reset
        add(0, 0, 1, 0, 0, 5,  32'h0,        2'b00, 0, 0,  1,  32'h20,      0,  0,  0); // issue x5
        add(0, 0, 1, 0, 0, 6,  32'h20,       2'b00, 0, 0,  0,  32'h20,      0,  0,  1); // RAW stall
        add(0, 0, 1, 0, 0, 5,  32'h20,       2'b01, 5, 0,  0,  32'h0,       0,  0,  2); // no bypass
        add(0, 0, 1, 0, 0, 5,  32'h20,       2'b00, 0, 0,  1,  32'h20,      0,  0,  2); // now fires
        add(0, 0, 0, 0, 0, 0,  32'h0,        2'b01, 5, 0,  0,  32'h0,       0,  0,  2);
        add(0, 0, 1, 0, 0, 0,  32'h0,        2'b00, 0, 0,  1,  32'h0,       0,  0,  2); // rd=x0
        add(0, 0, 0, 0, 0, 0,  32'h0,        2'b01, 0, 0,  0,  32'h0,       0,  0,  2); // wb x0
        add(0, 0, 1, 0, 0, 9,  32'h0,        2'b00, 0, 0,  1,  32'h200,     0,  0,  2);
        add(0, 0, 0, 0, 0, 0,  32'h0,        2'b11, 9, 9,  0,  32'h0,       0,  0,  2); // dual wb
        add(0, 0, 0, 0, 0, 0,  32'h0,        2'b10, 0, 7,  0,  32'h0,       0,  1,  2); // wb x7
        add(0, 0, 0, 0, 0, 0,  32'h0,        2'b00, 0, 0,  0,  32'h0,       0,  1,  2); // sticky
        add(0, 0, 1, 0, 0, 2,  32'h0,        2'b00, 0, 0,  1,  32'h4,       0,  1,  2);
        add(0, 0, 1, 0, 0, 3,  32'h0,        2'b00, 0, 0,  1,  32'hC,       0,  1,  2); // b2b
        add(0, 0, 1, 1, 0, 1,  32'h0,        2'b00, 0, 0,  0,  32'hC,       1,  1,  3); // DRAIN
        add(0, 0, 1, 1, 0, 1,  32'h0,        2'b11, 2, 3,  0,  32'h0,       1,  1,  4);
        add(0, 0, 1, 1, 0, 1,  32'h0,        2'b00, 0, 0,  1,  32'hFFFFFFFF, 1, 1,  4); // BLOCKED
        add(0, 0, 1, 0, 0, 4,  32'h0,        2'b00, 0, 0,  0,  32'hFFFFFFFF, 1, 1,  5);
        add(0, 0, 0, 0, 0, 0,  32'h0,        2'b01, 4, 0,  0,  32'hFFFFFFFF, 1, 1,  5); // wb ign
        add(0, 0, 0, 0, 1, 0,  32'h0,        2'b00, 0, 0,  0,  32'h0,       0,  1,  5); // done
        add(0, 0, 1, 0, 1, 4,  32'h0,        2'b00, 0, 0,  1,  32'h10,      0,  1,  5); // done ign
        add(0, 0, 1, 0, 0, 5,  32'h0,        2'b00, 0, 0,  1,  32'h30,      0,  1,  5);
        add(0, 0, 1, 1, 0, 1,  32'h0,        2'b00, 0, 0,  0,  32'h30,      1,  1,  6); // DRAIN
        add(0, 1, 1, 1, 0, 1,  32'h0,        2'b00, 0, 0,  0,  32'h0,       0,  1,  6); // flush
        add(0, 0, 1, 1, 0, 1,  32'h0,        2'b00, 0, 0,  1,  32'hFFFFFFFF, 1, 1,  6);
        add(1, 0, 0, 0, 0, 0,  32'h0,        2'b00, 0, 0,  0,  32'h0,       0,  0,  0); // rst
        add(0, 0, 1, 0, 0, 31, 32'h0,        2'b00, 0, 0,  1,  32'h80000000, 0, 0,  0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            chk($sformatf("v%0d ready", i), 32'(pl_ready), 32'(vecs[i].e_ready));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d locks", i), locks, vecs[i].e_locks);
            chk($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
            chk($sformatf("v%0d err", i), 32'(err), 32'(vecs[i].e_err));
            chk($sformatf("v%0d stall", i), stall_cnt, vecs[i].e_stall);
        end

        // DRAIN abandoned when decode drops the blocking request: back to RUN, locks kept.
        idle = vecs[0];
        idle.rst = 1'b0;
        @(negedge clk);
        drive(idle);
        pl_valid = 1'b1; blocking = 1'b1; rd = 5'd1;
        #1;
        chk("drain_enter ready", 32'(pl_ready), 32'h0);
        @(posedge clk);
        #1;
        chk("drain_enter busy", 32'(busy), 32'h1);
        chk("drain_enter stall", stall_cnt, 32'h1);
        @(negedge clk);
        drive(idle);
        @(posedge clk);
        #1;
        chk("drain_exit busy", 32'(busy), 32'h0);
        chk("drain_exit locks", locks, 32'h80000000);
        chk("drain_exit stall", stall_cnt, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
